note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter PITCH_BITWIDTH, default 9: width of pitch clock-divider maxval.
REQ-002 SHALL have parameter DUR_BITWIDTH, default 13: width of note duration, in fs samples.
REQ-003 SHALL have parameter FS_DIV, default 125: clk cycles per fs sample (10 MHz / 125 = 80 kHz).
REQ-004 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: note-memory write strobe.
REQ-007 SHALL have port wr_addr, input, 5: note-memory write address, 0..31.
REQ-008 SHALL have port wr_pitch, input, PITCH_BITWIDTH: pitch maxval to store; 0 = rest.
REQ-009 SHALL have port wr_dur, input, DUR_BITWIDTH: duration to store, in fs samples.
REQ-010 SHALL have port len, input, 6: melody length in notes, 0..32; sampled on accepted start.
REQ-011 SHALL have port start, input, 1: single-cycle play request.
REQ-012 SHALL have port stop, input, 1: abort request.
REQ-013 SHALL have port pitch_maxval, output, PITCH_BITWIDTH: drives the sine clkgen maxval.
REQ-014 SHALL have port gate, output, 1: high while a non-rest note sounds; enables the DACs.
REQ-015 SHALL have port note_strobe, output, 1: one-cycle pulse on every note change; resets the sine clkgen phase.
REQ-016 SHALL have port note_idx, output, 5: index of the current note.
REQ-017 SHALL have port busy, output, 1: high in LOAD, PLAY and GAP.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at melody end.

Function
REQ-019 SHALL store 32 entries of {pitch, dur} in a register array; a write SHALL take effect on the next edge and SHALL be ignored while busy=1.
REQ-020 SHALL run the FSM IDLE -> LOAD -> PLAY -> GAP -> (LOAD | DONE) -> IDLE.
REQ-021 SHALL, in IDLE, accept start only if busy=0; with len=0 it SHALL go to DONE, otherwise it SHALL latch len, set note_idx=0 and go to LOAD.
REQ-022 SHALL, in LOAD (1 cycle), register pitch_maxval=mem[note_idx].pitch, clear the duration counter and the fs divider, pulse note_strobe, and go to PLAY.
REQ-023 SHALL, in PLAY, drive gate=1 iff pitch_maxval!=0, and count one duration step per fs tick (divider reaches FS_DIV-1).
REQ-024 SHALL leave PLAY after max(dur,1) fs ticks, so dur=0 plays as dur=1.
REQ-025 SHALL, in GAP, hold gate=0 for exactly one fs tick (articulation).
REQ-026 SHALL, after GAP, go to LOAD with note_idx+1 if note_idx < len-1, otherwise go to DONE.
REQ-027 SHALL, in DONE (1 cycle), pulse done=1 and then go to IDLE.
REQ-028 SHALL give stop priority over every other event: from any busy state, the next state SHALL be IDLE with gate=0, and done SHALL NOT pulse.
REQ-029 SHALL ignore start while busy, and SHALL ignore start when stop is asserted in the same cycle.
REQ-030 SHALL hold pitch_maxval at its last value in IDLE; gate SHALL be 0 outside PLAY.

Reset
REQ-031 SHALL, on reset, set state=IDLE, pitch_maxval=0, gate=0, note_strobe=0, note_idx=0, busy=0, done=0, and clear all counters.
REQ-032 SHALL leave note-memory contents unaffected by reset; reset mid-play SHALL silence gate on the next edge.

Configuration
REQ-033 SHALL, with macro NOTE_SEQUENCER_LOOP_EN defined, add input loop (1 bit); with loop=1 at the end of the last GAP it SHALL go to LOAD with note_idx=0 and SHALL NOT pulse done.
REQ-034 SHALL, without NOTE_SEQUENCER_LOOP_EN, have no loop port and SHALL always end in DONE.

Verification
REQ-035 SHALL test: FS_DIV=4, one note {pitch=177, dur=3}, len=1, start -> note_strobe 1 cycle after start, gate high 12 cycles, gate low 4 cycles, then done pulse.
REQ-036 SHALL test: a rest note {pitch=0, dur=2} -> gate stays 0 for that note, pitch_maxval=0, note_strobe still pulses.
REQ-037 SHALL test: len=0 with start -> done 1 cycle later, gate never rises.
REQ-038 SHALL test: stop asserted mid-note 2 of 3 -> gate=0 and busy=0 on the next edge, no done; a write while busy leaves memory unchanged.
REQ-039 SHALL test: dur=0 entry -> note plays 1 fs tick; a start during PLAY is ignored and note_idx does not restart.
REQ-040 SHALL test: with NOTE_SEQUENCER_LOOP_EN defined, loop=1, len=2 -> note_idx sequence 0,1,0,1 with no done; dropping loop to 0 ends after index 1 with done.

Source files
------------

// File: rtl/note_sequencer.sv
// Melody player: steps through a 32-entry {pitch, dur} note memory, driving a sine clkgen and DAC gate.
// Optional NOTE_SEQUENCER_LOOP_EN adds a loop input that restarts the melody instead of finishing.
module note_sequencer #(
    parameter int unsigned PITCH_BITWIDTH = 9,
    parameter int unsigned DUR_BITWIDTH   = 13,
    parameter int unsigned FS_DIV         = 125
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [4:0]                wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    input  logic [5:0]                len,
    input  logic                      start,
    input  logic                      stop,
    output logic [PITCH_BITWIDTH-1:0] pitch_maxval,
    output logic                      gate,
    output logic                      note_strobe,
    output logic [4:0]                note_idx,
    output logic                      busy,
    output logic                      done
`ifdef NOTE_SEQUENCER_LOOP_EN
    ,
    input  logic                      loop
`endif
);

    localparam int unsigned DIV_W = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam int unsigned DEPTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    logic [PITCH_BITWIDTH-1:0] pitch_mem [DEPTH];
    logic [DUR_BITWIDTH-1:0]   dur_mem   [DEPTH];

    state_t                    state_q, state_d;
    logic [4:0]                idx_d;
    logic [5:0]                len_q, len_d;
    logic [PITCH_BITWIDTH-1:0] pitch_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [DUR_BITWIDTH-1:0]   dur_q, dur_d;
    logic                      gate_d, strobe_d, busy_d, done_d;

    logic                      fs_tick;
    logic [DUR_BITWIDTH-1:0]   cur_dur;
    logic [DUR_BITWIDTH-1:0]   dur_last;
    logic                      last_note;

    // Note memory is not reset and is frozen while a melody is running
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            pitch_mem[wr_addr] <= wr_pitch;
            dur_mem[wr_addr]   <= wr_dur;
        end
    end

    assign fs_tick   = (div_q == DIV_W'(FS_DIV - 1));
    assign cur_dur   = dur_mem[note_idx];
    // A zero duration is treated as one tick
    assign dur_last  = (cur_dur <= DUR_BITWIDTH'(1)) ? '0 : cur_dur - DUR_BITWIDTH'(1);
    assign last_note = ((6'(note_idx) + 6'd1) >= len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            note_idx     <= '0;
            len_q        <= '0;
            pitch_maxval <= '0;
            div_q        <= '0;
            dur_q        <= '0;
            gate         <= 1'b0;
            note_strobe  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_idx     <= idx_d;
            len_q        <= len_d;
            pitch_maxval <= pitch_d;
            div_q        <= div_d;
            dur_q        <= dur_d;
            gate         <= gate_d;
            note_strobe  <= strobe_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = note_idx;
        len_d   = len_q;
        pitch_d = pitch_maxval;
        div_d   = div_q;
        dur_d   = dur_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (len == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = len;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                pitch_d = pitch_mem[note_idx];
                div_d   = '0;
                dur_d   = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                div_d = fs_tick ? '0 : div_q + DIV_W'(1);
                if (fs_tick) begin
                    if (dur_q == dur_last) begin
                        dur_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        dur_d = dur_q + DUR_BITWIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                div_d = fs_tick ? '0 : div_q + DIV_W'(1);
                if (fs_tick) begin
                    if (!last_note) begin
                        idx_d   = note_idx + 5'd1;
                        state_d = S_LOAD;
`ifdef NOTE_SEQUENCER_LOOP_EN
                    end else if (loop) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any progress made above
        if (stop && (state_q inside {S_LOAD, S_PLAY, S_GAP})) begin
            state_d = S_IDLE;
        end

        busy_d   = (state_d inside {S_LOAD, S_PLAY, S_GAP});
        gate_d   = (state_d == S_PLAY) && (pitch_d != '0);
        strobe_d = (state_d == S_LOAD);
        done_d   = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues timed output events, a monitor compares them.
module tb_note_sequencer;

    localparam int unsigned PW = 9;
    localparam int unsigned DW = 13;
    localparam int FSD = 4;

    localparam int EV_STROBE = 0;
    localparam int EV_RISE   = 1;
    localparam int EV_FALL   = 2;
    localparam int EV_DONE   = 3;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [PW-1:0] wr_pitch;
    logic [DW-1:0] wr_dur;
    logic [5:0]    len;
    logic          start;
    logic          stop;
    logic [PW-1:0] pitch_maxval;
    logic          gate;
    logic          note_strobe;
    logic [4:0]    note_idx;
    logic          busy;
    logic          done;
`ifdef NOTE_SEQUENCER_LOOP_EN
    logic          loop;
`endif

    note_sequencer #(
        .PITCH_BITWIDTH(PW),
        .DUR_BITWIDTH  (DW),
        .FS_DIV        (FSD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_pitch    (wr_pitch),
        .wr_dur      (wr_dur),
        .len         (len),
        .start       (start),
        .stop        (stop),
        .pitch_maxval(pitch_maxval),
        .gate        (gate),
        .note_strobe (note_strobe),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done)
`ifdef NOTE_SEQUENCER_LOOP_EN
        ,
        .loop        (loop)
`endif
    );

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    logic gate_prev = 1'b0;
    ev_t  exp_q[$];
    int   m_pitch [32];
    int   m_dur   [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_STROBE: return "strobe";
            EV_RISE:   return "gate_rise";
            EV_FALL:   return "gate_fall";
            default:   return "done";
        endcase
    endfunction

    function automatic void push_ev(input int k, input int c, input int d, input int stop_at);
        ev_t e;
        if (stop_at == 0 || c < stop_at) begin
            e.kind = k;
            e.cyc  = c;
            e.data = d;
            exp_q.push_back(e);
        end
    endfunction

    // Model of the event timeline: each note is LOAD + FSD*max(dur,1) PLAY + FSD GAP cycles
    function automatic int push_melody(input int cs, input int ln, input int passes, input int stop_at);
        int s = cs;
        int d;
        ev_t e;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < ln; i++) begin
                d = (m_dur[i] == 0) ? 1 : m_dur[i];
                push_ev(EV_STROBE, s, i, stop_at);
                if (m_pitch[i] != 0) begin
                    push_ev(EV_RISE, s + 1, m_pitch[i], stop_at);
                    push_ev(EV_FALL, s + 1 + FSD * d, 0, stop_at);
                    if (stop_at > s + 1 && stop_at <= s + 1 + FSD * d) begin
                        e.kind = EV_FALL;
                        e.cyc  = stop_at;
                        e.data = 0;
                        exp_q.push_back(e);
                    end
                end
                s = s + FSD * d + FSD + 1;
            end
        end
        push_ev(EV_DONE, s, 0, stop_at);
        return (stop_at != 0) ? stop_at : s;
    endfunction

    task automatic check_ev(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got cycle %0d data %0d, required no event", ev_name(kind), cyc, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                errors++;
                $display("FAIL event: got %s cycle %0d data %0d, required %s cycle %0d data %0d",
                         ev_name(kind), cyc, data, ev_name(e.kind), e.cyc, e.data);
            end
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (note_strobe)         check_ev(EV_STROBE, int'(note_idx));
            if (gate && !gate_prev)  check_ev(EV_RISE, int'(pitch_maxval));
            if (!gate && gate_prev)  check_ev(EV_FALL, 0);
            if (done)                check_ev(EV_DONE, 0);
        end
        gate_prev = gate;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic write_note(input int a, input int p, input int d, input bit update_model);
        wr_en    = 1'b1;
        wr_addr  = 5'(a);
        wr_pitch = PW'(p);
        wr_dur   = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
        if (update_model) begin
            m_pitch[a] = p;
            m_dur[a]   = d;
        end
    endtask

    task automatic go(input int ln, input int passes, input int stop_off, output int cs, output int ec);
        len   = 6'(ln);
        start = 1'b1;
        cs    = cyc + 1;
        ec    = push_melody(cs, ln, passes, (stop_off == 0) ? 0 : cs + stop_off);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cs;
        int ec;
        for (int i = 0; i < 32; i++) begin
            m_pitch[i] = 0;
            m_dur[i]   = 0;
        end
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
        len = '0; start = 1'b0; stop = 1'b0;
`ifdef NOTE_SEQUENCER_LOOP_EN
        loop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_pitch_maxval", int'(pitch_maxval), 0);
        check("reset_gate", int'(gate), 0);
        check("reset_note_strobe", int'(note_strobe), 0);
        check("reset_note_idx", int'(note_idx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        mon_en = 1;

        write_note(0, 177, 3, 1);
        write_note(1, 0, 2, 1);
        write_note(2, 100, 1, 1);

        // Single note: 12 cycles of gate, 4-cycle gap, then done
        go(1, 1, 0, cs, ec);
        wait_until(cs + 6);
        check("single_busy_mid", int'(busy), 1);
        check("single_gate_mid", int'(gate), 1);
        wait_until(ec + 2);
        check("single_busy_after", int'(busy), 0);

        // Zero length finishes immediately
        go(0, 1, 0, cs, ec);
        wait_until(ec + 3);

        // Three notes with a rest in the middle
        go(3, 1, 0, cs, ec);
        wait_until(cs + 20);
        check("rest_pitch_maxval", int'(pitch_maxval), 0);
        check("rest_gate", int'(gate), 0);
        wait_until(ec + 2);

        // Stop during note 1 of 3; a write while busy must be ignored
        write_note(1, 60, 2, 1);
        go(3, 1, 21, cs, ec);
        wait_until(cs + 5);
        write_note(0, 5, 9, 0);
        wait_until(cs + 20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_gate", int'(gate), 0);
        check("stop_busy", int'(busy), 0);
        wait_until(cs + 40);
        go(1, 1, 0, cs, ec);
        wait_until(ec + 2);

        // Zero duration plays one tick; a start during PLAY is ignored
        write_note(0, 200, 0, 1);
        go(2, 1, 0, cs, ec);
        wait_until(cs + 3);
        len   = 6'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(cs + 12);
        check("restart_ignored_idx", int'(note_idx), 1);
        wait_until(ec + 2);

        // Reset mid-play silences gate and keeps memory
        go(1, 1, 3, cs, ec);
        wait_until(cs + 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_gate", int'(gate), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_pitch", int'(pitch_maxval), 0);
        wait_until(cs + 8);
        go(1, 1, 0, cs, ec);
        wait_until(ec + 2);

`ifdef NOTE_SEQUENCER_LOOP_EN
        write_note(0, 177, 1, 1);
        write_note(1, 90, 1, 1);
        loop = 1'b1;
        go(2, 2, 0, cs, ec);
        wait_until(cs + 20);
        loop = 1'b0;
        wait_until(ec + 2);
`endif

        repeat (5) @(negedge clk);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_%s: got nothing, required cycle %0d data %0d", ev_name(e.kind), e.cyc, e.data);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
